// File: rtl/alu_pipe.sv
// alu_pipe: handshaked, registered execute-stage ALU.
// Single-cycle ops produce a result one cycle after accept. MUL runs a
// WIDTH-iteration shift-add loop and returns the full double-width product.
// A tag travels with every operation so results can be matched to requests.
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [TAG_W-1:0] out_tag,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int S  = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_GT   = 4'b0110;
  localparam logic [3:0] OP_LT   = 4'b0111;
  localparam logic [3:0] OP_PASS = 4'b1001;
  localparam logic [3:0] OP_SHL  = 4'b1010;
  localparam logic [3:0] OP_SHR  = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1100;
  localparam logic [3:0] OP_SLT  = 4'b1101;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t               state_r;
  logic [CW-1:0]        cnt_r;
  logic [WIDTH-1:0]     mcand_r;
  // Upper half accumulates partial sums, lower half starts as the multiplier
  // and is shifted out one bit per iteration while product bits shift in.
  logic [2*WIDTH-1:0]   acc_r;
  logic [TAG_W-1:0]     mtag_r;

  logic                 out_valid_r;
  logic [WIDTH-1:0]     result_r;
  logic [WIDTH-1:0]     result_hi_r;
  logic [TAG_W-1:0]     out_tag_r;
  logic                 flag_z_r;
  logic                 flag_n_r;
  logic                 flag_c_r;
  logic                 flag_v_r;

  logic                 accept_s;
  logic [WIDTH:0]       sum_s;
  logic [WIDTH:0]       diff_s;
  logic [S-1:0]         shamt_s;
  logic [WIDTH-1:0]     res_s;
  logic                 c_s;
  logic                 v_s;
  logic [WIDTH:0]       madd_s;
  logic [2*WIDTH-1:0]   acc_nxt_s;

  assign in_ready  = (state_r == IDLE) && (!out_valid_r || out_ready);
  assign accept_s  = in_valid && in_ready;

  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign result_hi = result_hi_r;
  assign out_tag   = out_tag_r;
  assign flag_z    = flag_z_r;
  assign flag_n    = flag_n_r;
  assign flag_c    = flag_c_r;
  assign flag_v    = flag_v_r;

  // Single-cycle datapath: result plus carry/overflow for every non-MUL opcode.
  always_comb begin
    sum_s   = {1'b0, a} + {1'b0, b};
    diff_s  = {1'b0, a} - {1'b0, b};
    shamt_s = b[S-1:0];
    res_s   = {WIDTH{1'b0}};
    c_s     = 1'b0;
    v_s     = 1'b0;
    case (opcode)
      OP_ADD: begin
        res_s = sum_s[WIDTH-1:0];
        c_s   = sum_s[WIDTH];
        v_s   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res_s = diff_s[WIDTH-1:0];
        c_s   = diff_s[WIDTH];
        v_s   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  res_s = a & b;
      OP_OR:   res_s = a | b;
      OP_XOR:  res_s = a ^ b;
      OP_GT:   res_s = {{(WIDTH-1){1'b0}}, (a > b)};
      OP_LT:   res_s = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_PASS: res_s = a;
      OP_SHL:  res_s = a << shamt_s;
      OP_SHR:  res_s = a >> shamt_s;
      OP_SRA:  res_s = $unsigned($signed(a) >>> shamt_s);
      OP_SLT:  res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: res_s = {WIDTH{1'b0}};
    endcase
  end

  // One shift-add multiply iteration: conditionally add the multiplicand to
  // the upper half, then shift the whole accumulator right by one.
  always_comb begin
    madd_s    = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
              + {1'b0, (acc_r[0] ? mcand_r : {WIDTH{1'b0}})};
    acc_nxt_s = {madd_s, acc_r[WIDTH-1:1]};
  end

  // Control FSM with registered result, flags, tag and valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      mcand_r     <= {WIDTH{1'b0}};
      acc_r       <= {(2*WIDTH){1'b0}};
      mtag_r      <= {TAG_W{1'b0}};
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      result_hi_r <= {WIDTH{1'b0}};
      out_tag_r   <= {TAG_W{1'b0}};
      flag_z_r    <= 1'b0;
      flag_n_r    <= 1'b0;
      flag_c_r    <= 1'b0;
      flag_v_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            if (opcode == OP_MUL) begin
              // Any previous result drained on this edge, so valid drops.
              state_r     <= MUL;
              cnt_r       <= {CW{1'b0}};
              mcand_r     <= a;
              acc_r       <= {{WIDTH{1'b0}}, b};
              mtag_r      <= in_tag;
              out_valid_r <= 1'b0;
            end else begin
              out_valid_r <= 1'b1;
              result_r    <= res_s;
              result_hi_r <= {WIDTH{1'b0}};
              out_tag_r   <= in_tag;
              flag_z_r    <= (res_s == {WIDTH{1'b0}});
              flag_n_r    <= res_s[WIDTH-1];
              flag_c_r    <= c_s;
              flag_v_r    <= v_s;
            end
          end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
          end else begin
            out_valid_r <= out_valid_r;
          end
        end
        MUL: begin
          acc_r <= acc_nxt_s;
          if (cnt_r == CW'(WIDTH - 1)) begin
            state_r     <= IDLE;
            cnt_r       <= {CW{1'b0}};
            out_valid_r <= 1'b1;
            result_r    <= acc_nxt_s[WIDTH-1:0];
            result_hi_r <= acc_nxt_s[2*WIDTH-1:WIDTH];
            out_tag_r   <= mtag_r;
            flag_z_r    <= (acc_nxt_s[WIDTH-1:0] == {WIDTH{1'b0}});
            flag_n_r    <= acc_nxt_s[WIDTH-1];
            flag_c_r    <= 1'b0;
            flag_v_r    <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed, scoreboarded bench for alu_pipe at WIDTH=16 and WIDTH=32.
module tb_alu_pipe;

  typedef struct packed {
    logic [63:0] lo;
    logic [63:0] hi;
    logic [7:0]  tag;
    logic        z;
    logic        n;
    logic        c;
    logic        v;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        iv16, ir16, ov16, or16, z16, n16, c16, v16;
  logic [15:0] a16, b16, r16, rh16;
  logic [3:0]  op16, it16, ot16;

  logic        iv32, ir32, ov32, or32, z32, n32, c32, v32;
  logic [31:0] a32, b32, r32, rh32;
  logic [3:0]  op32, it32, ot32;

  int n_cmp = 0;
  int n_err = 0;
  exp_t q16[$];
  exp_t q32[$];

  alu_pipe #(.WIDTH(16), .TAG_W(4)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .opcode(op16), .in_tag(it16), .out_valid(ov16), .out_ready(or16), .result(r16),
    .result_hi(rh16), .out_tag(ot16), .flag_z(z16), .flag_n(n16), .flag_c(c16), .flag_v(v16));

  alu_pipe #(.WIDTH(32), .TAG_W(4)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .opcode(op32), .in_tag(it32), .out_valid(ov32), .out_ready(or32), .result(r32),
    .result_hi(rh32), .out_tag(ot32), .flag_z(z32), .flag_n(n32), .flag_c(c32), .flag_v(v32));

  // Reference model working on 64/128-bit values masked to width w.
  function automatic exp_t model(input int w, input logic [63:0] ai, input logic [63:0] bi,
                                 input logic [3:0] op, input logic [3:0] tag);
    exp_t e;
    logic [63:0]  mask, x, y;
    logic [64:0]  full;
    logic [127:0] wide, wsh;
    longint sa, sb, r, maxs, mins;
    int sh;
    mask = (64'd1 << w) - 64'd1;
    x    = ai & mask;
    y    = bi & mask;
    sa   = x[w-1] ? longint'(x | ~mask) : longint'(x);
    sb   = y[w-1] ? longint'(y | ~mask) : longint'(y);
    maxs = (longint'(1) <<< (w - 1)) - 1;
    mins = -(longint'(1) <<< (w - 1));
    sh   = int'(y % 64'(w));
    e     = '0;
    e.tag = {4'd0, tag};
    case (op)
      4'd0: begin
        full = {1'b0, x} + {1'b0, y};
        e.lo = full[63:0] & mask;
        e.c  = full[w];
        r    = sa + sb;
        e.v  = (r > maxs) || (r < mins);
      end
      4'd1: begin
        e.lo = (x - y) & mask;
        e.c  = (x < y);
        r    = sa - sb;
        e.v  = (r > maxs) || (r < mins);
      end
      4'd2: begin
        wide = {64'd0, x} * {64'd0, y};
        e.lo = wide[63:0] & mask;
        wsh  = wide >> w;
        e.hi = wsh[63:0] & mask;
      end
      4'd3:  e.lo = x & y;
      4'd4:  e.lo = x | y;
      4'd5:  e.lo = x ^ y;
      4'd6:  e.lo = {63'd0, (x > y)};
      4'd7:  e.lo = {63'd0, (x < y)};
      4'd9:  e.lo = x;
      4'd10: e.lo = (x << sh) & mask;
      4'd11: e.lo = x >> sh;
      4'd12: e.lo = 64'(sa >>> sh) & mask;
      4'd13: e.lo = {63'd0, (sa < sb)};
      default: e.lo = 64'd0;
    endcase
    e.z = (e.lo == 64'd0);
    e.n = e.lo[w-1];
    return e;
  endfunction

  task automatic check(input string name, input logic [139:0] obs, input logic [139:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Scoreboard for the 16-bit instance: pop and compare on every transfer out.
  always @(negedge clk) begin
    if (rst_n && ov16 && or16) begin
      if (q16.size() == 0) begin
        check("u16_unexpected_result", {124'd0, ot16, r16}, 140'd0 | 140'h1_0000_0000);
      end else begin
        check("u16_result", {64'(r16), 64'(rh16), 8'(ot16), z16, n16, c16, v16}, q16.pop_front());
      end
    end
  end

  // Scoreboard for the 32-bit instance.
  always @(negedge clk) begin
    if (rst_n && ov32 && or32) begin
      if (q32.size() == 0) begin
        check("u32_unexpected_result", {104'd0, ot32, r32}, 140'h1_0000_0000_0000);
      end else begin
        check("u32_result", {64'(r32), 64'(rh32), 8'(ot32), z32, n32, c32, v32}, q32.pop_front());
      end
    end
  end

  // Offer one operation; wait (bounded) for acceptance and record stall cycles.
  task automatic send(input bit w32, input logic [63:0] av, input logic [63:0] bv,
                      input logic [3:0] op, input logic [3:0] tag, output int stalls);
    bit done;
    done   = 1'b0;
    stalls = 0;
    if (w32) begin
      a32 = av[31:0]; b32 = bv[31:0]; op32 = op; it32 = tag; iv32 = 1'b1;
    end else begin
      a16 = av[15:0]; b16 = bv[15:0]; op16 = op; it16 = tag; iv16 = 1'b1;
    end
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if ((w32 ? ir32 : ir16) === 1'b1) begin
        if (w32) q32.push_back(model(32, av, bv, op, tag));
        else     q16.push_back(model(16, av, bv, op, tag));
        done = 1'b1;
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
    end
    iv16 = 1'b0;
    iv32 = 1'b0;
    if (!done) check("send_timeout", 140'd0, 140'd1);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  logic [15:0] ta[14], tbv[14];
  logic [3:0]  top[14];
  exp_t        eh;
  int          st, tot;
  bit          any_ov;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    iv16 = 1'b0; a16 = '0; b16 = '0; op16 = '0; it16 = '0; or16 = 1'b1;
    iv32 = 1'b0; a32 = '0; b32 = '0; op32 = '0; it32 = '0; or32 = 1'b1;
    tick(3);

    // Reset state
    @(negedge clk);
    check("rst_ov16", {139'd0, ov16}, 140'd0);
    check("rst_out16", {88'd0, r16, rh16, ot16, z16, n16, c16, v16}, 140'd0);
    check("rst_ir16", {139'd0, ir16}, 140'd1);
    check("rst_out32", {55'd0, ov32, r32, rh32, ot32, z32, n32, c32, v32}, 140'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ADD wrap to zero, latency 1
    send(1'b0, 64'hFFFF, 64'h0001, 4'b0000, 4'd3, st);
    check("add_latency", {139'd0, ov16}, 140'd1);
    tick(1);
    check("drain_no_accept", {139'd0, ov16}, 140'd0);

    // Assorted single-cycle ops, issued back to back
    ta  = '{16'h8000, 16'hFFFF, 16'hFFFF, 16'h8000, 16'hFFFF, 16'h00F0, 16'hAAAA,
            16'h1234, 16'h0001, 16'h8000, 16'h1234, 16'h5678, 16'h0001, 16'h7FFF};
    tbv = '{16'h0001, 16'h0001, 16'h0001, 16'h0013, 16'h0001, 16'h0F00, 16'hFFFF,
            16'h9999, 16'h0014, 16'h000F, 16'h1111, 16'h2222, 16'h0002, 16'h0001};
    top = '{4'b0001, 4'b1101, 4'b0111, 4'b1100, 4'b0110, 4'b0100, 4'b0101,
            4'b1001, 4'b1010, 4'b1011, 4'b1000, 4'b1111, 4'b0001, 4'b0000};
    for (int i = 0; i < 14; i++) send(1'b0, 64'(ta[i]), 64'(tbv[i]), top[i], 4'(i), st);
    tick(2);

    // MUL: stall for WIDTH cycles, held in_valid accepted only afterwards
    send(1'b0, 64'h1234, 64'h0100, 4'b0010, 4'd9, st);
    send(1'b0, 64'h0001, 64'h0002, 4'b0000, 4'hA, st);
    check("mul16_stall_cycles", 140'(st), 140'd16);
    tick(2);

    // Backpressure hold then drain+accept on one edge
    send(1'b0, 64'hF0F0, 64'h3C3C, 4'b0011, 4'd5, st);
    or16 = 1'b0;
    eh = model(16, 64'hF0F0, 64'h3C3C, 4'b0011, 4'd5);
    repeat (5) begin
      @(negedge clk);
      check("bp_hold", {114'd0, r16, ot16, z16, n16, c16, v16, ir16, ov16},
            {114'd0, eh.lo[15:0], eh.tag[3:0], eh.z, eh.n, eh.c, eh.v, 1'b0, 1'b1});
    end
    @(posedge clk); #1;
    or16 = 1'b1;
    send(1'b0, 64'h1357, 64'h2468, 4'b0101, 4'd6, st);
    check("bp_drain_accept_stall", 140'(st), 140'd0);
    check("bp_new_valid", {139'd0, ov16}, 140'd1);
    tick(2);

    // Back-to-back XORs
    tot = 0;
    for (int t = 0; t < 8; t++) begin
      send(1'b0, 64'($urandom_range(0, 65535)), 64'($urandom_range(0, 65535)), 4'b0101, 4'(t), st);
      tot += st;
    end
    check("b2b_stalls", 140'(tot), 140'd0);
    tick(3);

    // Reset mid-MUL aborts without a result
    send(1'b0, 64'h1234, 64'h0100, 4'b0010, 4'hC, st);
    tick(6);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    void'(q16.pop_back());
    @(negedge clk);
    check("mulrst_ov_ir", {138'd0, ov16, ir16}, 140'd1);
    any_ov = 1'b0;
    repeat (20) begin @(negedge clk); any_ov |= ov16; end
    check("mulrst_no_stale", {139'd0, any_ov}, 140'd0);
    @(posedge clk); #1;
    send(1'b0, 64'h0005, 64'h0007, 4'b0000, 4'd1, st);
    tick(2);

    // WIDTH=32 ADD and full-width MUL
    send(1'b1, 64'hFFFFFFFF, 64'h1, 4'b0000, 4'd3, st);
    send(1'b1, 64'hFFFFFFFF, 64'hFFFFFFFF, 4'b0010, 4'd6, st);
    send(1'b1, 64'h0, 64'h0, 4'b0100, 4'd7, st);
    check("mul32_stall_cycles", 140'(st), 140'd32);
    tick(3);

    check("q16_empty", 140'(q16.size()), 140'd0);
    check("q32_empty", 140'(q32.size()), 140'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised-width, handshaked ALU for the execute stage. It is the registered successor to the combinational 16-bit ALU.
- Adds valid/ready flow control, a registered output and a multi-cycle shift-add multiplier that returns the full double-width product.
- Adds shift and signed-compare ops, and full N/Z/C/V flags.
- A TAG field passes through alongside each operation so the pipeline can match results to their instructions.

Parameters:
- WIDTH, 16: operand and result width; legal range 4..64.
- TAG_W, 4: width of the passthrough tag.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  block accepts this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- opcode  in  4  operation select
- in_tag  in  TAG_W  tag captured with the operation
- out_valid  out  1  result held valid
- out_ready  in  1  consumer takes result
- result  out  WIDTH  low result / low product
- result_hi  out  WIDTH  high product half (MUL only, else 0)
- out_tag  out  TAG_W  tag of the result
- flag_z  out  1  result == 0
- flag_n  out  1  result[WIDTH-1]
- flag_c  out  1  ADD carry-out / SUB borrow (a<b unsigned); 0 for other ops
- flag_v  out  1  signed overflow for ADD/SUB; 0 for other ops

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset values: out_valid=0, result=0, result_hi=0, out_tag=0, all flags 0, state IDLE, iteration counter 0.
- Reset mid-MUL aborts the multiply; no result is produced.
- Opcodes (unsigned unless noted):
  - 0000 ADD, 0001 SUB, 0010 MUL.
  - 0011 AND, 0100 OR, 0101 XOR.
  - 0110 GT: result=1 if a>b, else 0.
  - 0111 LT: result=1 if a<b, else 0.
  - 1001 PASS: result=a.
  - 1010 SHL: a<<b[S-1:0].
  - 1011 SHR: logical a>>b[S-1:0].
  - 1100 SRA: arithmetic a>>>b[S-1:0].
  - 1101 SLT: signed a<b gives 1.
  - All others: result=0, flag_z=1.
  - S=$clog2(WIDTH). Shift amount is the low S bits of b only, i.e. taken mod WIDTH.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH. MUL is unsigned; {result_hi,result} = a*b, 2*WIDTH bits.
- Flags are registered together with result and are computed on the low WIDTH bits.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Accept occurs when in_valid && in_ready at a rising edge.
  - A transfer out occurs when out_valid && out_ready.
- States:
  - IDLE: non-MUL accept writes result, flags and out_tag at the accept edge. out_valid=1 from the next cycle, so latency is 1.
  - IDLE to MUL: a MUL accept latches a, b and the tag, and clears the accumulator and counter. out_valid falls if the old result drained on that edge.
  - MUL: one shift-add iteration per edge for WIDTH edges. in_ready=0 throughout. in_valid is ignored and the stall persists across the whole multiply.
  - MUL to IDLE: the WIDTH-th iteration edge writes result, result_hi, flags and out_tag, sets out_valid=1 and returns to IDLE. Latency is WIDTH cycles from accept.
- Output hold: while out_valid && !out_ready, result, result_hi, out_tag and flags stay stable, and in_ready=0.
- Simultaneous drain and accept on the same edge: the new result replaces the old one and out_valid stays 1. This gives throughput of 1 op/cycle for non-MUL ops.
- Drain with no accept: out_valid falls to 0 on that edge; result keeps its stale value (don't-care).
- Inputs a, b, opcode and in_tag are sampled only on the accept edge; changes at other times have no effect.

Test Plan:
- WIDTH=16, ADD a=FFFF b=0001 tag=3, out_ready=1 -> next cycle out_valid=1, result=0000, flag_z=1, flag_c=1, flag_v=0, out_tag=3.
- SUB a=8000 b=0001 -> result=7FFF, flag_v=1, flag_n=0, flag_c=0; then SLT a=FFFF b=0001 -> 1; LT a=FFFF b=0001 -> 0; SRA a=8000 b=0013 -> F000 (shift 3).
- MUL a=1234 b=0100 -> in_ready=0 for 16 cycles; out_valid rises 16 cycles after accept with result=3400, result_hi=0012; a second in_valid held during MUL is accepted only afterwards.
- Backpressure: out_ready=0 after an AND result -> result/flags/out_tag stable and in_ready=0 for 5 cycles; out_ready=1 with new in_valid -> drain and accept on the same edge, next result 1 cycle later.
- Back-to-back: 8 XOR ops with in_valid=1 and out_ready=1 -> 8 results on 8 consecutive cycles, tags in order.
- Reset mid-MUL: rst_n=0 for one edge at iteration 7 -> out_valid=0, in_ready=1 after release, no stale result. Repeat the ADD/MUL checks at WIDTH=32: FFFFFFFF*FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
